// File: rtl/seq_divider_32by16_pkg.sv
// Shared widths, FSM encoding and constants for the
// 32-by-16 sequential restoring divider.
package seq_divider_32by16_pkg;
    localparam int W  = 16;
    localparam int CW = $clog2(W) + 1;

    localparam logic [W-1:0]  ALL_ONES = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/seq_divider_32by16_if.sv
// Request/result bundle between a divider client
// and the divider.
interface seq_divider_32by16_if;
    import seq_divider_32by16_pkg::*;

    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder,
        input  div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder,
        output div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider_32by16_div_step.sv
// One restoring-division step: trial subtract of the
// divisor from the shifted partial remainder.
module seq_divider_32by16_div_step
    import seq_divider_32by16_pkg::*;
(
    input  logic [W:0]   i_t,
    input  logic [W-1:0] i_dvsr,
    output logic [W:0]   o_r,
    output logic         o_qbit
);
    logic [W:0] w_dvsr;
    logic [W:0] w_diff;

    assign w_dvsr = {1'b0, i_dvsr};
    assign w_diff = i_t - w_dvsr;
    assign o_qbit = (i_t >= w_dvsr);
    assign o_r    = o_qbit ? w_diff : i_t;
endmodule

// File: rtl/seq_divider_32by16.sv
// Iterative restoring divider, one quotient bit per
// clock, with divide-by-zero and overflow precheck.
module seq_divider_32by16
    import seq_divider_32by16_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    seq_divider_32by16_if.slave   bus
);
    logic [1:0]    r_state;
    logic [W:0]    r_rem;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_dvsr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_remo;
    logic          r_dbz;
    logic          r_ovf;

    logic          w_accept;
    logic [W-1:0]  w_hi;
    logic          w_zero;
    logic          w_big;
    logic [W:0]    w_t;
    logic [W:0]    w_r;
    logic          w_qbit;
    logic [W-1:0]  w_qnext;

    assign w_hi     = bus.dividend[2*W-1:W];
    assign w_zero   = (bus.divisor == '0);
    assign w_big    = (w_hi >= bus.divisor);
    assign w_accept = bus.start &&
                      (r_state == IDLE || r_state == DONE);

    assign w_t     = {r_rem[W-1:0], r_q[W-1]};
    assign w_qnext = {r_q[W-2:0], w_qbit};

    seq_divider_32by16_div_step u_step (
        .i_t    (w_t),
        .i_dvsr (r_dvsr),
        .o_r    (w_r),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_q     <= '0;
            r_dvsr  <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
            if (w_zero) begin
                r_dbz   <= 1'b1;
                r_quot  <= ALL_ONES;
                r_remo  <= bus.dividend[W-1:0];
                r_state <= DONE;
            end else if (w_big) begin
                r_ovf   <= 1'b1;
                r_quot  <= ALL_ONES;
                r_remo  <= '0;
                r_state <= DONE;
            end else begin
                r_rem   <= {1'b0, w_hi};
                r_q     <= bus.dividend[W-1:0];
                r_dvsr  <= bus.divisor;
                r_cnt   <= '0;
                r_state <= CALC;
            end
        end else begin
            case (r_state)
                CALC: begin
                    r_rem <= w_r;
                    r_q   <= w_qnext;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_quot  <= w_qnext;
                        r_remo  <= w_r[W-1:0];
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state == CALC);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remo;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_seq_divider_32by16.sv
// Directed checks of the sequential divider: normal,
// error, ignored start, mid-divide reset, back-to-back.
module tb_seq_divider_32by16;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_divider_32by16_if bus ();

    seq_divider_32by16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc counts negedges after the accepting edge;
    // done after N edges shows up at cyc == N+1.
    task automatic wait_done(input bit hold,
                             output int cyc,
                             output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!hold) bus.start = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.done) break;
        end
    endtask

    task automatic launch(input logic [31:0] a,
                          input logic [15:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero,
             bus.overflow, bus.quotient,
             bus.remainder} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outs got busy=%b done=%b q=%h r=%h",
                     bus.busy, bus.done, bus.quotient,
                     bus.remainder);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal();
        int cyc, bcnt;
        launch(32'd1000, 16'd7);
        wait_done(1'b0, cyc, bcnt);
        checks++;
        if (cyc !== 17) begin
            errors++;
            $display("FAIL norm_latency got %0d exp 17", cyc);
        end
        checks++;
        if (bcnt !== 16) begin
            errors++;
            $display("FAIL norm_busy got %0d exp 16", bcnt);
        end
        checks++;
        if (bus.quotient !== 16'd142 ||
            bus.remainder !== 16'd6) begin
            errors++;
            $display("FAIL norm_result got %0d r %0d exp 142 r 6",
                     bus.quotient, bus.remainder);
        end
        checks++;
        if (bus.div_by_zero !== 1'b0 ||
            bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL norm_flags got %b%b exp 00",
                     bus.div_by_zero, bus.overflow);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b exp 0 0",
                     bus.done, bus.busy);
        end
        checks++;
        if (bus.quotient !== 16'd142) begin
            errors++;
            $display("FAIL result_hold got %0d exp 142",
                     bus.quotient);
        end
    endtask

    task automatic test_max_product();
        int cyc, bcnt;
        launch(32'hFFFE0001, 16'hFFFF);
        wait_done(1'b0, cyc, bcnt);
        checks++;
        if (cyc !== 17 || bus.quotient !== 16'hFFFF ||
            bus.remainder !== 16'h0) begin
            errors++;
            $display("FAIL max_product got cyc=%0d q=%h r=%h exp 17 ffff 0000",
                     cyc, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_div_zero();
        int cyc, bcnt;
        launch(32'd1234, 16'd0);
        wait_done(1'b0, cyc, bcnt);
        checks++;
        if (cyc !== 1 || bcnt !== 0) begin
            errors++;
            $display("FAIL dbz_timing got cyc=%0d busy=%0d exp 1 0",
                     cyc, bcnt);
        end
        checks++;
        if (bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0 ||
            bus.quotient !== 16'hFFFF ||
            bus.remainder !== 16'h04D2) begin
            errors++;
            $display("FAIL dbz_result got z=%b o=%b q=%h r=%h exp 1 0 ffff 04d2",
                     bus.div_by_zero, bus.overflow,
                     bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_overflow();
        int cyc, bcnt;
        launch(32'h00010000, 16'd1);
        wait_done(1'b0, cyc, bcnt);
        checks++;
        if (cyc !== 1 || bcnt !== 0) begin
            errors++;
            $display("FAIL ovf_timing got cyc=%0d busy=%0d exp 1 0",
                     cyc, bcnt);
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.div_by_zero !== 1'b0 ||
            bus.quotient !== 16'hFFFF ||
            bus.remainder !== 16'h0) begin
            errors++;
            $display("FAIL ovf_result got z=%b o=%b q=%h r=%h exp 0 1 ffff 0000",
                     bus.div_by_zero, bus.overflow,
                     bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_ignore_start();
        int cyc, bcnt;
        launch(32'd1000, 16'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 16'd5;
        wait_done(1'b0, cyc, bcnt);
        checks++;
        if (cyc !== 13 || bus.quotient !== 16'd142 ||
            bus.remainder !== 16'd6) begin
            errors++;
            $display("FAIL ignore_start got cyc=%0d q=%0d r=%0d exp 13 142 6",
                     cyc, bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int cyc, bcnt;
        launch(32'd1000, 16'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero,
             bus.overflow, bus.quotient,
             bus.remainder} !== 36'h0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b q=%h r=%h exp all 0",
                     bus.busy, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(32'd50, 16'd5);
        wait_done(1'b0, cyc, bcnt);
        checks++;
        if (cyc !== 17 || bus.quotient !== 16'd10 ||
            bus.remainder !== 16'd0) begin
            errors++;
            $display("FAIL after_reset got cyc=%0d q=%0d r=%0d exp 17 10 0",
                     cyc, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        launch(32'd100, 16'd3);
        wait_done(1'b1, cyc, bcnt);
        checks++;
        if (cyc !== 17 || bus.quotient !== 16'd33 ||
            bus.remainder !== 16'd1) begin
            errors++;
            $display("FAIL b2b_first got cyc=%0d q=%0d r=%0d exp 17 33 1",
                     cyc, bus.quotient, bus.remainder);
        end
        bus.dividend = 32'd77;
        bus.divisor  = 16'd7;
        wait_done(1'b1, cyc, bcnt);
        bus.start = 1'b0;
        checks++;
        if (cyc !== 17 || bcnt !== 16) begin
            errors++;
            $display("FAIL b2b_no_bubble got cyc=%0d busy=%0d exp 17 16",
                     cyc, bcnt);
        end
        checks++;
        if (bus.quotient !== 16'd11 || bus.remainder !== 16'd0) begin
            errors++;
            $display("FAIL b2b_second got q=%0d r=%0d exp 11 0",
                     bus.quotient, bus.remainder);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_normal();
        test_max_product();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
